// File: rtl/graph_fetch_unit.sv
// graph_fetch_unit
// ----------------
// Fetches one graph vertex record for the traversal controller.
//   Record layout at base A: A = neighbor count N, A+1..A+DIM = data words,
//   A+DIM+1..A+DIM+N = neighbor addresses.
// The header and data words are read over memory port 1, one outstanding
// request at a time, with tags 0 (header) and 1..DIM (data words).
// Neighbor addresses are read over memory port 2 with tag 15. They are pushed
// into an internal FIFO that drains one entry per cycle to the next stage.
//
// Ports
//   clk_in, rst_in            clock, asynchronous active-high reset
//   v_addr_in, valid_in       vertex base address and start request
//   ready_out                 a start is accepted (IDLE or DONE)
//   data_out, data_valid_out  fetched data words and their per-word valids
//   neigh_fifo_out            popped neighbor address, qualified by neigh_valid_out
//   neigh_deq_out             pop strobe (combinational)
//   neigh_full_out            FIFO status (combinational)
//   neigh_empty_out           FIFO status (combinational)
//   mem_valid_out             port 1 request strobe
//   mem_req_out               port 1 request {tag, addr}
//   mem_valid_in              port 1 response strobe
//   mem_data_in               port 1 response {tag, data}
//   mem_valid_out2, mem_req_out2, mem_valid_in2, mem_data_in2
//                             port 2 equivalents of the four port 1 signals
//   fully_fetched_out         whole record fetched; held until the next start
module graph_fetch_unit #(
    parameter int DIM        = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [31:0]               v_addr_in,
    input  logic                      valid_in,
    output logic                      ready_out,
    output logic [DIM-1:0][31:0]      data_out,
    output logic [DIM-1:0]            data_valid_out,
    output logic [31:0]               neigh_fifo_out,
    output logic                      neigh_valid_out,
    output logic                      neigh_deq_out,
    output logic                      neigh_full_out,
    output logic                      neigh_empty_out,
    output logic                      mem_valid_out,
    output logic [35:0]               mem_req_out,
    input  logic                      mem_valid_in,
    input  logic [35:0]               mem_data_in,
    output logic                      mem_valid_out2,
    output logic [35:0]               mem_req_out2,
    input  logic                      mem_valid_in2,
    input  logic [35:0]               mem_data_in2,
    output logic                      fully_fetched_out
);

    localparam int IDX_W = $clog2(DIM + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, HDR_REQ, HDR_WAIT, FETCH, DONE} state_t;

    state_t                state_q, state_d;
    logic [31:0]           base_q, base_d;
    logic [31:0]           n_q, n_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  p1_wait_q, p1_wait_d;
    logic [31:0]           k_iss_q, k_iss_d;
    logic                  p2_wait_q, p2_wait_d;
    logic [DIM-1:0][31:0]  data_q, data_d;
    logic [DIM-1:0]        dvalid_q, dvalid_d;
    logic                  ff_q, ff_d;
    logic                  mv1_q, mv1_d;
    logic [35:0]           req1_q, req1_d;
    logic                  mv2_q, mv2_d;
    logic [35:0]           req2_q, req2_d;
    logic [31:0]           nfo_q, nfo_d;
    logic                  nvalid_q, nvalid_d;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           fifo_mem [FIFO_DEPTH];

    logic [3:0] tag_exp;
    logic       p1_acc, p2_acc, push, pop;

    // Data word i is requested with tag i+1.
    assign tag_exp = 4'(idx_q) + 4'd1;

    assign p1_acc = (state_q == FETCH) && p1_wait_q && mem_valid_in &&
                    (mem_data_in[35:32] == tag_exp);
    assign p2_acc = (state_q == FETCH) && p2_wait_q && mem_valid_in2 &&
                    (mem_data_in2[35:32] == 4'hF);

    assign push  = p2_acc;
    assign pop   = (cnt_q != '0);
    assign cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

    assign ready_out         = (state_q == IDLE) || (state_q == DONE);
    assign neigh_deq_out     = pop;
    assign neigh_full_out    = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign neigh_empty_out   = (cnt_q == '0);
    assign data_out          = data_q;
    assign data_valid_out    = dvalid_q;
    assign neigh_fifo_out    = nfo_q;
    assign neigh_valid_out   = nvalid_q;
    assign mem_valid_out     = mv1_q;
    assign mem_req_out       = req1_q;
    assign mem_valid_out2    = mv2_q;
    assign mem_req_out2      = req2_q;
    assign fully_fetched_out = ff_q;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        n_d       = n_q;
        idx_d     = idx_q;
        p1_wait_d = p1_wait_q;
        k_iss_d   = k_iss_q;
        p2_wait_d = p2_wait_q;
        data_d    = data_q;
        dvalid_d  = dvalid_q;
        ff_d      = ff_q;
        mv1_d     = 1'b0;
        req1_d    = req1_q;
        mv2_d     = 1'b0;
        req2_d    = req2_q;
        nvalid_d  = pop;
        nfo_d     = pop ? fifo_mem[rd_ptr_q] : nfo_q;

        case (state_q)
            IDLE, DONE: begin
                if (valid_in) begin
                    base_d    = v_addr_in;
                    dvalid_d  = '0;
                    ff_d      = 1'b0;
                    idx_d     = '0;
                    k_iss_d   = '0;
                    p1_wait_d = 1'b0;
                    p2_wait_d = 1'b0;
                    state_d   = HDR_REQ;
                end
            end
            HDR_REQ: begin
                mv1_d   = 1'b1;
                req1_d  = {4'h0, base_q};
                state_d = HDR_WAIT;
            end
            HDR_WAIT: begin
                if (mem_valid_in && (mem_data_in[35:32] == 4'h0)) begin
                    n_d       = mem_data_in[31:0];
                    state_d   = FETCH;
                    mv1_d     = 1'b1;
                    req1_d    = {4'h1, base_q + 32'd1};
                    p1_wait_d = 1'b1;
                    idx_d     = '0;
                    // Leftover entries from the previous vertex may still
                    // occupy the FIFO, so the credit check applies here too.
                    if ((mem_data_in[31:0] != 32'd0) && (cnt_d < CNT_W'(FIFO_DEPTH))) begin
                        mv2_d     = 1'b1;
                        req2_d    = {4'hF, base_q + 32'(DIM) + 32'd1};
                        k_iss_d   = 32'd1;
                        p2_wait_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (p1_acc) begin
                    for (int i = 0; i < DIM; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            data_d[i]   = mem_data_in[31:0];
                            dvalid_d[i] = 1'b1;
                        end
                    end
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(DIM - 1)) begin
                        p1_wait_d = 1'b0;
                    end else begin
                        mv1_d  = 1'b1;
                        req1_d = {tag_exp + 4'd1, base_q + 32'(idx_q) + 32'd2};
                    end
                end

                if (p2_acc) begin
                    p2_wait_d = 1'b0;
                end
                // cnt_d already reflects this cycle's push and pop, and nothing
                // else is outstanding once p2_wait_d is low, so an issue here
                // always leaves room for its own response.
                if (!p2_wait_d && (k_iss_q < n_q) && (cnt_d < CNT_W'(FIFO_DEPTH))) begin
                    mv2_d     = 1'b1;
                    req2_d    = {4'hF, base_q + 32'(DIM) + 32'd1 + k_iss_q};
                    k_iss_d   = k_iss_q + 32'd1;
                    p2_wait_d = 1'b1;
                end

                if ((idx_d == IDX_W'(DIM)) && (k_iss_d == n_q) && !p2_wait_d) begin
                    state_d = DONE;
                    ff_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            base_q    <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            p1_wait_q <= 1'b0;
            k_iss_q   <= '0;
            p2_wait_q <= 1'b0;
            data_q    <= '0;
            dvalid_q  <= '0;
            ff_q      <= 1'b0;
            mv1_q     <= 1'b0;
            req1_q    <= '0;
            mv2_q     <= 1'b0;
            req2_q    <= '0;
            nfo_q     <= '0;
            nvalid_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            p1_wait_q <= p1_wait_d;
            k_iss_q   <= k_iss_d;
            p2_wait_q <= p2_wait_d;
            data_q    <= data_d;
            dvalid_q  <= dvalid_d;
            ff_q      <= ff_d;
            mv1_q     <= mv1_d;
            req1_q    <= req1_d;
            mv2_q     <= mv2_d;
            req2_q    <= req2_d;
            nfo_q     <= nfo_d;
            nvalid_q  <= nvalid_d;
            wr_ptr_q  <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q  <= rd_ptr_q + PTR_W'(pop);
            cnt_q     <= cnt_d;
        end
    end

    // Storage needs no reset: reset clears the pointers, which empties the FIFO.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_data_in2[31:0];
        end
    end

endmodule

// File: tb/tb_graph_fetch_unit.sv
// Testbench for graph_fetch_unit: directed sequence with randomized records
// and memory latencies, checked against a record-level reference model.
module tb_graph_fetch_unit;

    localparam int DIM        = 2;
    localparam int FIFO_DEPTH = 16;

    logic                 clk_in;
    logic                 rst_in;
    logic [31:0]          v_addr_in;
    logic                 valid_in;
    logic                 ready_out;
    logic [DIM-1:0][31:0] data_out;
    logic [DIM-1:0]       data_valid_out;
    logic [31:0]          neigh_fifo_out;
    logic                 neigh_valid_out;
    logic                 neigh_deq_out;
    logic                 neigh_full_out;
    logic                 neigh_empty_out;
    logic                 mem_valid_out;
    logic [35:0]          mem_req_out;
    logic                 mem_valid_in;
    logic [35:0]          mem_data_in;
    logic                 mem_valid_out2;
    logic [35:0]          mem_req_out2;
    logic                 mem_valid_in2;
    logic [35:0]          mem_data_in2;
    logic                 fully_fetched_out;

    graph_fetch_unit #(.DIM(DIM), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .v_addr_in         (v_addr_in),
        .valid_in          (valid_in),
        .ready_out         (ready_out),
        .data_out          (data_out),
        .data_valid_out    (data_valid_out),
        .neigh_fifo_out    (neigh_fifo_out),
        .neigh_valid_out   (neigh_valid_out),
        .neigh_deq_out     (neigh_deq_out),
        .neigh_full_out    (neigh_full_out),
        .neigh_empty_out   (neigh_empty_out),
        .mem_valid_out     (mem_valid_out),
        .mem_req_out       (mem_req_out),
        .mem_valid_in      (mem_valid_in),
        .mem_data_in       (mem_data_in),
        .mem_valid_out2    (mem_valid_out2),
        .mem_req_out2      (mem_req_out2),
        .mem_valid_in2     (mem_valid_in2),
        .mem_data_in2      (mem_data_in2),
        .fully_fetched_out (fully_fetched_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int tests = 0;
    int fails = 0;

    // Memory image and memory-model controls.
    // mode 0: both ports answer requests; mode 1: port 1 holds {0, 6};
    // mode 2: both ports drive the stray_* values.
    logic [31:0] mem_arr [logic [31:0]];
    int          mode = 0;
    int          dmax = 0;
    logic        stray_v1 = 1'b0, stray_v2 = 1'b0;
    logic [35:0] stray_d1 = '0, stray_d2 = '0;

    // Monitor state.
    int          cyc = 0;
    logic [31:0] got [$];
    logic [35:0] p1_reqs [$];
    int          p2_cnt = 0;
    int          last_resp = 0;
    int          ff_rise = -1;
    int          full_push = 0;
    logic        ff_prev = 1'b0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : (32'hDEAD0000 ^ a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (neigh_valid_out) got.push_back(neigh_fifo_out);
        if (mem_valid_out) p1_reqs.push_back(mem_req_out);
        if (mem_valid_out2) p2_cnt++;
        if (mem_valid_in && mem_data_in[35:32] != 4'h0) last_resp = cyc;
        if (mem_valid_in2 && mem_data_in2[35:32] == 4'hF) begin
            last_resp = cyc;
            if (neigh_full_out) full_push++;
        end
        if (fully_fetched_out && !ff_prev) ff_rise = cyc;
        ff_prev = fully_fetched_out;
    end

    // Port 1 memory model: answers the earliest one cycle after the request
    // pulse, plus 0..dmax extra cycles, echoing the request tag.
    initial begin : port1_mem
        int          cnt;
        logic        pend;
        logic [35:0] req;
        pend = 1'b0; cnt = 0; req = '0;
        mem_valid_in = 1'b0; mem_data_in = '0;
        forever begin
            @(posedge clk_in); #1;
            if (mode == 2) begin
                pend = 1'b0;
                mem_valid_in = stray_v1; mem_data_in = stray_d1;
            end else if (mode == 1) begin
                mem_valid_in = 1'b1; mem_data_in = {4'h0, 32'd6};
            end else if (rst_in) begin
                pend = 1'b0; mem_valid_in = 1'b0;
            end else begin
                mem_valid_in = 1'b0;
                if (pend) begin
                    if (cnt == 0) begin
                        mem_valid_in = 1'b1;
                        mem_data_in  = {req[35:32], rd(req[31:0])};
                        pend = 1'b0;
                    end else cnt--;
                end
                if (mem_valid_out) begin
                    pend = 1'b1; req = mem_req_out; cnt = $urandom_range(0, dmax);
                end
            end
        end
    end

    initial begin : port2_mem
        int          cnt;
        logic        pend;
        logic [35:0] req;
        pend = 1'b0; cnt = 0; req = '0;
        mem_valid_in2 = 1'b0; mem_data_in2 = '0;
        forever begin
            @(posedge clk_in); #1;
            if (mode == 2) begin
                pend = 1'b0;
                mem_valid_in2 = stray_v2; mem_data_in2 = stray_d2;
            end else if (rst_in) begin
                pend = 1'b0; mem_valid_in2 = 1'b0;
            end else begin
                mem_valid_in2 = 1'b0;
                if (pend) begin
                    if (cnt == 0) begin
                        mem_valid_in2 = 1'b1;
                        mem_data_in2  = {req[35:32], rd(req[31:0])};
                        pend = 1'b0;
                    end else cnt--;
                end
                if (mem_valid_out2) begin
                    pend = 1'b1; req = mem_req_out2; cnt = $urandom_range(0, dmax);
                end
            end
        end
    end

    task automatic clr_mon();
        @(posedge clk_in); #2;
        got.delete(); p1_reqs.delete();
        p2_cnt = 0; last_resp = 0; ff_rise = -1; full_push = 0;
    endtask

    task automatic start(input logic [31:0] a);
        @(negedge clk_in); v_addr_in = a; valid_in = 1'b1;
        @(negedge clk_in); valid_in = 1'b0;
    endtask

    task automatic wait_ff(input int lim);
        for (int c = 0; c < lim && !fully_fetched_out; c++) @(negedge clk_in);
    endtask

    task automatic build(input logic [31:0] base, input int n);
        mem_arr.delete();
        mem_arr[base] = n;
        for (int i = 0; i < DIM; i++) mem_arr[base + 1 + i] = $urandom;
        for (int k = 0; k < n; k++) mem_arr[base + DIM + 1 + k] = $urandom;
    endtask

    // Fetches the record at base and checks every observable result against
    // the record as laid out in memory.
    task automatic run_record(input string tag, input logic [31:0] base, input int lim);
        logic [31:0] exp_n;
        logic [31:0] exp_nb [$];
        exp_n = rd(base);
        exp_nb.delete();
        for (int k = 0; k < int'(exp_n); k++) exp_nb.push_back(rd(base + DIM + 1 + k));
        clr_mon();
        start(base);
        wait_ff(lim);
        repeat (20) @(negedge clk_in);
        check({tag, " fully_fetched"}, 64'(fully_fetched_out), 64'd1);
        check({tag, " ready"}, 64'(ready_out), 64'd1);
        check({tag, " data_valid"}, 64'(data_valid_out), 64'((1 << DIM) - 1));
        for (int i = 0; i < DIM; i++)
            check($sformatf("%s data[%0d]", tag, i), 64'(data_out[i]), 64'(rd(base + 1 + i)));
        check({tag, " port2 requests"}, 64'(p2_cnt), 64'(exp_n));
        check({tag, " neighbor count"}, 64'(got.size()), 64'(exp_nb.size()));
        for (int k = 0; k < exp_nb.size(); k++)
            check($sformatf("%s neighbor[%0d]", tag, k),
                  64'(k < got.size() ? got[k] : 32'hFFFF_FFFF), 64'(exp_nb[k]));
        check({tag, " done latency"}, 64'(ff_rise), 64'(last_resp + 1));
        check({tag, " full at push"}, 64'(full_push), 64'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst_in = 1'b1; valid_in = 1'b0; v_addr_in = '0;
        repeat (3) @(negedge clk_in);

        // Reset values.
        check("rst ready", 64'(ready_out), 64'd1);
        check("rst data_valid", 64'(data_valid_out), 64'd0);
        check("rst data_out", 64'(data_out), 64'd0);
        check("rst fully_fetched", 64'(fully_fetched_out), 64'd0);
        check("rst neigh_empty", 64'(neigh_empty_out), 64'd1);
        check("rst neigh_full", 64'(neigh_full_out), 64'd0);
        check("rst neigh_valid", 64'(neigh_valid_out), 64'd0);
        check("rst neigh_fifo_out", 64'(neigh_fifo_out), 64'd0);
        check("rst mem_valid_out", 64'(mem_valid_out), 64'd0);
        check("rst mem_req_out", 64'(mem_req_out), 64'd0);
        check("rst mem_valid_out2", 64'(mem_valid_out2), 64'd0);
        check("rst mem_req_out2", 64'(mem_req_out2), 64'd0);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);

        // Header response held high with tag 0: header read once, N=6,
        // port 1 stalls on tag 1.
        mem_arr.delete();
        for (int k = 0; k < 6; k++) mem_arr[32'd4 + k] = 32'h5000 + k;
        mode = 1; dmax = 0;
        clr_mon();
        start(32'd1);
        repeat (40) @(negedge clk_in);
        check("hold req count", 64'(p1_reqs.size()), 64'd2);
        check("hold hdr req", 64'(p1_reqs.size() > 0 ? p1_reqs[0] : 36'hF_FFFF_FFFF), 64'({4'h0, 32'd1}));
        check("hold data req", 64'(p1_reqs.size() > 1 ? p1_reqs[1] : 36'hF_FFFF_FFFF), 64'({4'h1, 32'd2}));
        check("hold fully_fetched", 64'(fully_fetched_out), 64'd0);
        check("hold data_valid", 64'(data_valid_out), 64'd0);
        check("hold port2 requests", 64'(p2_cnt), 64'd6);
        check("hold neighbor count", 64'(got.size()), 64'd6);
        for (int k = 0; k < 6; k++)
            check($sformatf("hold neighbor[%0d]", k),
                  64'(k < got.size() ? got[k] : 32'hFFFF_FFFF), 64'(32'h5000 + k));
        mode = 0;
        @(negedge clk_in); rst_in = 1'b1;
        @(negedge clk_in); rst_in = 1'b0;
        repeat (2) @(negedge clk_in);

        // Full record from the worked example.
        mem_arr.delete();
        mem_arr[32'h100] = 3;
        mem_arr[32'h101] = 32'hAA; mem_arr[32'h102] = 32'hBB;
        mem_arr[32'h103] = 32'h10; mem_arr[32'h104] = 32'h20; mem_arr[32'h105] = 32'h30;
        dmax = 2;
        run_record("rec100", 32'h100, 300);

        // New start from DONE clears the valids and the done flag next cycle.
        build(32'h200, 0);
        start(32'h200);
        check("restart data_valid", 64'(data_valid_out), 64'd0);
        check("restart fully_fetched", 64'(fully_fetched_out), 64'd0);
        check("restart ready", 64'(ready_out), 64'd0);
        wait_ff(300);
        repeat (5) @(negedge clk_in);

        // N = 0: no port 2 traffic, done right after the last data word.
        build(32'h280, 0);
        run_record("n0", 32'h280, 300);

        // N = 40 exceeds the FIFO depth; responses one cycle after request.
        dmax = 0;
        build(32'h300, 40);
        run_record("n40", 32'h300, 1000);

        // Random records with random latencies.
        for (int r = 0; r < 3; r++) begin
            logic [31:0] b;
            b = 32'h1000 * (r + 1) + $urandom_range(0, 255);
            dmax = $urandom_range(0, 3);
            build(b, $urandom_range(0, 20));
            run_record($sformatf("rand%0d", r), b, 1000);
        end

        // Asynchronous reset in the middle of FETCH.
        dmax = 3;
        build(32'h400, 10);
        clr_mon();
        start(32'h400);
        repeat (10) @(negedge clk_in);
        check("midrst pre fully_fetched", 64'(fully_fetched_out), 64'd0);
        mode = 2;
        stray_v1 = 1'b0; stray_v2 = 1'b0;
        rst_in = 1'b1;
        #1;
        check("midrst ready", 64'(ready_out), 64'd1);
        check("midrst data_valid", 64'(data_valid_out), 64'd0);
        check("midrst data_out", 64'(data_out), 64'd0);
        check("midrst fully_fetched", 64'(fully_fetched_out), 64'd0);
        check("midrst neigh_empty", 64'(neigh_empty_out), 64'd1);
        check("midrst neigh_valid", 64'(neigh_valid_out), 64'd0);
        check("midrst neigh_fifo_out", 64'(neigh_fifo_out), 64'd0);
        check("midrst mem_valid_out", 64'(mem_valid_out), 64'd0);
        check("midrst mem_req_out", 64'(mem_req_out), 64'd0);
        check("midrst mem_valid_out2", 64'(mem_valid_out2), 64'd0);
        check("midrst mem_req_out2", 64'(mem_req_out2), 64'd0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        clr_mon();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_in);
            stray_v1 = 1'b1; stray_d1 = {4'(1 + (c % 2)), $urandom};
            stray_v2 = 1'b1; stray_d2 = {4'hF, $urandom};
        end
        repeat (3) @(negedge clk_in);
        check("stray neighbors", 64'(got.size()), 64'd0);
        check("stray port1 requests", 64'(p1_reqs.size()), 64'd0);
        check("stray port2 requests", 64'(p2_cnt), 64'd0);
        check("stray data_valid", 64'(data_valid_out), 64'd0);
        check("stray data_out", 64'(data_out), 64'd0);
        check("stray fully_fetched", 64'(fully_fetched_out), 64'd0);
        check("stray ready", 64'(ready_out), 64'd1);
        check("stray neigh_empty", 64'(neigh_empty_out), 64'd1);
        stray_v1 = 1'b0; stray_v2 = 1'b0;
        @(negedge clk_in);
        mode = 0;
        repeat (2) @(negedge clk_in);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
